// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending transaction path.
// States, key codes, coin values and the price lookup helper.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND_WAIT,
    ST_CHANGE
  } vend_state_e;

  localparam logic [3:0] KEY_COIN5  = 4'h1;
  localparam logic [3:0] KEY_COIN10 = 4'h2;
  localparam logic [3:0] KEY_COIN25 = 4'h3;
  localparam logic [3:0] KEY_SEL_A  = 4'h4;
  localparam logic [3:0] KEY_SEL_B  = 4'h5;
  localparam logic [3:0] KEY_SEL_C  = 4'h6;
  localparam logic [3:0] KEY_SEL_D  = 4'h7;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

  localparam logic [4:0] COIN5_V  = 5'd5;
  localparam logic [4:0] COIN10_V = 5'd10;
  localparam logic [4:0] COIN25_V = 5'd25;

  function automatic int unsigned price_of(
    input logic [1:0]  sel,
    input int unsigned pa,
    input int unsigned pb,
    input int unsigned pc,
    input int unsigned pd
  );
    int unsigned p;
    unique case (sel)
      2'd0:    p = pa;
      2'd1:    p = pb;
      2'd2:    p = pc;
      default: p = pd;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: keypad/motor/display bundle of the vend controller.
// slave = controller side, master = environment side.
interface vend_if #(
  parameter int unsigned CREDIT_W = 8
);
  logic                key_valid;
  logic [3:0]          key_code;
  logic                vend_ack;
  logic [CREDIT_W-1:0] credit;
  logic                vend_req;
  logic [1:0]          vend_sel;
  logic                change_pulse;
  logic                coin_reject;
  logic                insufficient;
  logic                busy;

  modport slave (
    input  key_valid,
    input  key_code,
    input  vend_ack,
    output credit,
    output vend_req,
    output vend_sel,
    output change_pulse,
    output coin_reject,
    output insufficient,
    output busy
  );

  modport master (
    output key_valid,
    output key_code,
    output vend_ack,
    input  credit,
    input  vend_req,
    input  vend_sel,
    input  change_pulse,
    input  coin_reject,
    input  insufficient,
    input  busy
  );
endinterface

// File: rtl/vend_change_timer.sv
// vend_change_timer: PERIOD-cycle down-counter; done_o on every PERIOD-th tick.
// Ports: clk, rst_n (async low), start_i (reload), tick_i (count), done_o.
module vend_change_timer #(
  parameter int unsigned PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int unsigned W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_o = 1'b0;
    if (start_i) begin
      cnt_d = LOAD;
    end else if (tick_i) begin
      if (cnt_q == '0) begin
        done_o = 1'b1;
        cnt_d  = LOAD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vend_controller.sv
// vend_controller: coin/select/cancel sequencer, dispense handshake, change payout.
// Ports: clk, reset (async low), bus (vend_if.slave). Option: VEND_TIMEOUT_EN.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned PRICE_A     = 25,
  parameter int unsigned PRICE_B     = 50,
  parameter int unsigned PRICE_C     = 75,
  parameter int unsigned PRICE_D     = 100,
  parameter int unsigned CHANGE_GAP  = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic  clk,
  input  logic  reset,
  vend_if.slave bus
);

  localparam int unsigned CW1 = CREDIT_W + 1;

  if (CHANGE_GAP < 2 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("vend_controller: bad CHANGE_GAP/ACK_TIMEOUT");
  end

  vend_state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic       req_q, req_d;
  logic [1:0] sel_q, sel_d;
  logic       pulse_q, pulse_d;
  logic       rej_q, rej_d;
  logic       insuf_q, insuf_d;
  logic       busy_q, busy_d;

  logic       chg_start, chg_tick, chg_done;

  logic       is_coin, is_sel, is_cancel;
  logic [4:0] coin_v;
  logic [CW1-1:0] sum_w;
  logic [CW1-1:0] price_w;
  logic [CW1-1:0] vprice_w;

  always_comb begin
    is_coin   = 1'b0;
    is_sel    = 1'b0;
    is_cancel = 1'b0;
    coin_v    = '0;
    unique case (1'b1)
      (bus.key_code == KEY_COIN5): begin
        is_coin = 1'b1;
        coin_v  = COIN5_V;
      end
      (bus.key_code == KEY_COIN10): begin
        is_coin = 1'b1;
        coin_v  = COIN10_V;
      end
      (bus.key_code == KEY_COIN25): begin
        is_coin = 1'b1;
        coin_v  = COIN25_V;
      end
      (bus.key_code >= KEY_SEL_A &&
       bus.key_code <= KEY_SEL_D): begin
        is_sel = 1'b1;
      end
      (bus.key_code == KEY_CANCEL): begin
        is_cancel = 1'b1;
      end
      default: ;
    endcase
  end

  // One extra bit so an overflowing coin is detected, never wrapped.
  assign sum_w = {1'b0, credit_q} + CW1'(coin_v);

  // Select keys 4..7 map straight onto product index 0..3.
  assign price_w = CW1'(price_of(bus.key_code[1:0],
    PRICE_A, PRICE_B, PRICE_C, PRICE_D));

  assign vprice_w = CW1'(price_of(sel_q,
    PRICE_A, PRICE_B, PRICE_C, PRICE_D));

`ifdef VEND_TIMEOUT_EN
  logic to_start, to_tick, to_done;

  vend_change_timer #(
    .PERIOD(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (reset),
    .start_i(to_start),
    .tick_i (to_tick),
    .done_o (to_done)
  );
`endif

  vend_change_timer #(
    .PERIOD(CHANGE_GAP)
  ) u_change_timer (
    .clk    (clk),
    .rst_n  (reset),
    .start_i(chg_start),
    .tick_i (chg_tick),
    .done_o (chg_done)
  );

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    req_d     = req_q;
    sel_d     = sel_q;
    pulse_d   = 1'b0;
    rej_d     = 1'b0;
    insuf_d   = 1'b0;
    chg_start = 1'b0;
    chg_tick  = 1'b0;
`ifdef VEND_TIMEOUT_EN
    to_start  = 1'b0;
    to_tick   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (bus.key_valid) begin
          if (is_coin) begin
            if (sum_w[CREDIT_W]) begin
              rej_d = 1'b1;
            end else begin
              credit_d = sum_w[CREDIT_W-1:0];
              state_d  = ST_CREDIT;
            end
          end else if (is_sel) begin
            if (state_q == ST_CREDIT &&
                {1'b0, credit_q} >= price_w) begin
              credit_d = credit_q - price_w[CREDIT_W-1:0];
              sel_d    = bus.key_code[1:0];
              req_d    = 1'b1;
              state_d  = ST_VEND_WAIT;
`ifdef VEND_TIMEOUT_EN
              to_start = 1'b1;
`endif
            end else begin
              insuf_d = 1'b1;
            end
          end else if (is_cancel &&
                       state_q == ST_CREDIT) begin
            state_d   = ST_CHANGE;
            chg_start = 1'b1;
          end
        end
      end
      ST_VEND_WAIT: begin
`ifdef VEND_TIMEOUT_EN
        to_tick = 1'b1;
`endif
        if (bus.vend_ack) begin
          req_d = 1'b0;
          if (credit_q != '0) begin
            state_d   = ST_CHANGE;
            chg_start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef VEND_TIMEOUT_EN
        else if (to_done) begin
          // Refund fits: the price was subtracted from this credit.
          req_d     = 1'b0;
          credit_d  = credit_q + vprice_w[CREDIT_W-1:0];
          state_d   = ST_CHANGE;
          chg_start = 1'b1;
        end
`endif
      end
      ST_CHANGE: begin
        chg_tick = 1'b1;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else if (chg_done) begin
          pulse_d  = 1'b1;
          credit_d = credit_q - CREDIT_W'(5);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_VEND_WAIT) ||
             (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      req_q    <= 1'b0;
      sel_q    <= 2'd0;
      pulse_q  <= 1'b0;
      rej_q    <= 1'b0;
      insuf_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      pulse_q  <= pulse_d;
      rej_q    <= rej_d;
      insuf_q  <= insuf_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.vend_req     = req_q;
  assign bus.vend_sel     = sel_q;
  assign bus.change_pulse = pulse_q;
  assign bus.coin_reject  = rej_q;
  assign bus.insufficient = insuf_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed scoreboard bench for vend_controller.
// Expected values queued at stimulus time, popped when outputs are sampled.
module tb_vend_controller;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  vend_if #(.CREDIT_W(8)) bus();

  vend_controller #(
    .CREDIT_W   (8),
    .PRICE_A    (25),
    .PRICE_B    (50),
    .PRICE_C    (75),
    .PRICE_D    (100),
    .CHANGE_GAP (4),
    .ACK_TIMEOUT(1000)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic push(input string t, input logic [31:0] e);
    sb_t s;
    s.tag = t;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t s;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: got %0d, no expected value", obs);
    end else begin
      s = sbq.pop_front();
      assert (obs === s.exp) else begin
        n_err++;
        $error("FAIL %s: got %0d expected %0d", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      n++;
      if (bus.change_pulse === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic drain(input int limit, output int np);
    np = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.change_pulse === 1'b1) np++;
      if (bus.busy === 1'b0) return;
    end
    np = -1;
  endtask

  int n;

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.vend_ack  = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    push("rst credit", 0);   chk(bus.credit);
    push("rst vend_req", 0); chk(bus.vend_req);
    push("rst busy", 0);     chk(bus.busy);
    push("rst pulse", 0);    chk(bus.change_pulse);
    rst_n = 1'b1;
    tick();

    push("coin25 a", 25); key(KEY_COIN25); chk(bus.credit);
    push("coin25 b", 50); key(KEY_COIN25); chk(bus.credit);
    push("coin10", 60);   key(KEY_COIN10); chk(bus.credit);
    push("selB credit", 10);
    push("selB req", 1);
    push("selB sel", 1);
    push("selB busy", 1);
    key(KEY_SEL_B);
    chk(bus.credit); chk(bus.vend_req);
    chk(bus.vend_sel); chk(bus.busy);

    push("vw coin credit", 10);
    push("vw coin reject", 0);
    push("vw coin req", 1);
    key(KEY_COIN10);
    chk(bus.credit); chk(bus.coin_reject); chk(bus.vend_req);

    repeat (3) tick();
    bus.vend_ack = 1'b1;
    tick();
    bus.vend_ack = 1'b0;
    push("ack req", 0);  chk(bus.vend_req);
    push("ack busy", 1); chk(bus.busy);
    wait_pulse(n);
    push("chg gap1", 4);      chk(n);
    push("chg credit1", 5);   chk(bus.credit);
    wait_pulse(n);
    push("chg gap2", 4);      chk(n);
    push("chg credit2", 0);   chk(bus.credit);
    push("chg busy last", 1); chk(bus.busy);
    tick();
    push("chg busy idle", 0); chk(bus.busy);

    for (int i = 0; i < 10; i++) key(KEY_COIN25);
    push("fill 250", 250); chk(bus.credit);
    push("ovf reject", 1);
    push("ovf credit", 250);
    key(KEY_COIN10);
    chk(bus.coin_reject); chk(bus.credit);
    tick();
    push("ovf reject drop", 0); chk(bus.coin_reject);
    push("coin5 255", 255); key(KEY_COIN5); chk(bus.credit);
    key(KEY_CANCEL);
    drain(400, n);
    push("drain255 pulses", 51); chk(n);
    push("drain255 credit", 0);  chk(bus.credit);

    key(KEY_COIN10);
    key(KEY_COIN10);
    push("insuf pulse", 1);
    push("insuf credit", 20);
    push("insuf busy", 0);
    push("insuf req", 0);
    key(KEY_SEL_A);
    chk(bus.insufficient); chk(bus.credit);
    chk(bus.busy); chk(bus.vend_req);
    push("ign code credit", 20);
    push("ign code flags", 0);
    key(4'h8);
    chk(bus.credit);
    chk({bus.coin_reject, bus.insufficient});
    key(KEY_COIN10);
    push("credit 35", 35); key(KEY_COIN5); chk(bus.credit);
    key(KEY_CANCEL);
    push("cancel busy", 1); chk(bus.busy);
    for (int k = 0; k < 7; k++) begin
      wait_pulse(n);
      push($sformatf("c35 gap%0d", k), 4);
      chk(n);
    end
    push("c35 credit", 0);    chk(bus.credit);
    push("c35 busy last", 1); chk(bus.busy);
    tick();
    push("c35 busy idle", 0); chk(bus.busy);

    push("idle sel insuf", 1);
    key(KEY_SEL_C); chk(bus.insufficient);
    push("idle cancel busy", 0);
    key(KEY_CANCEL); chk(bus.busy);

    key(KEY_COIN25);
    key(KEY_CANCEL);
    wait_pulse(n);
    push("midchg credit", 20); chk(bus.credit);
    tick();
    rst_n = 1'b0;
    #1;
    push("arst credit", 0); chk(bus.credit);
    push("arst busy", 0);   chk(bus.busy);
    push("arst req", 0);    chk(bus.vend_req);
    push("arst sel", 0);    chk(bus.vend_sel);
    push("arst pulses", 0);
    chk({bus.change_pulse, bus.coin_reject, bus.insufficient});
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) key(KEY_COIN25);
    push("selD sel", 3);
    push("selD credit", 0);
    push("selD req", 1);
    key(KEY_SEL_D);
    chk(bus.vend_sel); chk(bus.credit); chk(bus.vend_req);
`ifdef VEND_TIMEOUT_EN
    n = 0;
    while (bus.vend_req === 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    push("to cycles", 1000); chk(n);
    push("to credit", 100);  chk(bus.credit);
    push("to busy", 1);      chk(bus.busy);
    drain(200, n);
    push("to pulses", 20);   chk(n);
`else
    bus.vend_ack = 1'b1;
    tick();
    bus.vend_ack = 1'b0;
    push("selD ack req", 0);  chk(bus.vend_req);
    push("selD ack busy", 0); chk(bus.busy);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
